// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption sequencer: one full round per clock on a
// single 128-bit state register, round keys fetched by index.
module aes_round_sequencer #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy,
    output logic [RK_IDX_W-1:0] round_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(NR);

    // S-box bytes, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column, row r in byte r
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    // SubBytes and ShiftRows fused: row r of column c reads column c+r
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c+8*r +: 8] = sbox(s[32*((c+r)%4)+8*r +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[32*c +: 32] = mix_column(s[32*c +: 32]);
        end
        return o;
    endfunction

    state_e              state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [RK_IDX_W-1:0] round_cnt_q, round_cnt_d;
    logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [127:0]        sb_sr;
    logic [127:0]        mc;
    logic [127:0]        rnd_out;

    // Round datapath; the final round skips MixColumns
    always_comb begin
        sb_sr   = sub_shift(st_q);
        mc      = mix_columns(sb_sr);
        rnd_out = ((round_cnt_q == LAST) ? sb_sr : mc) ^ rk_data;
    end

    // Next-state, state register and registered output decode
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        round_cnt_d = round_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d        = in_data ^ rk_data;
                    round_cnt_d = RK_IDX_W'(1);
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                st_d = rnd_out;
                if (round_cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    round_cnt_d = round_cnt_q + RK_IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    round_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                round_cnt_d = '0;
            end
        endcase
        rk_idx_d    = (state_d == ROUND) ? round_cnt_d : '0;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Single FSM register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            round_cnt_q <= '0;
            rk_idx_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            round_cnt_q <= round_cnt_d;
            rk_idx_q    <= rk_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Ready is withheld while reset is held; data only visible when valid
    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? st_q : '0;
    assign busy      = busy_q;
    assign rk_idx    = rk_idx_q;
    assign round_cnt = round_cnt_q;

endmodule
